// File: rtl/adc_capture.sv
// ADC conversion sequencer: pulses WR on tick, waits for INT, captures DB.
// Ports: clk, rst(n), tick, INT, DB -> WR, data/valid/ready, busy, overrun, timeout_err.
module adc_capture #(
    parameter int DATA_W    = 8,
    parameter int WR_CYCLES = 2,
    parameter int TIMEOUT   = 1023,
    parameter int TO_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              INT,
    input  logic [DATA_W-1:0] DB,
    output logic              WR,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WAIT_HI,
        WAIT_LO,
        CAPTURE
    } state_t;

    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] WR_LAST = TO_W'(WR_CYCLES - 1);
    localparam logic [TO_W-1:0] ONE     = TO_W'(1);

    state_t            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              wr_q, wr_d;
    logic              ovr_q, ovr_d;
    logic              to_q, to_d;

    logic              int_s1, int_s2, int_s3;
    logic [DATA_W-1:0] db_s1, db_s2;
    logic              rise, fall;

    // DB rides alongside INT so db_s2 is aligned with int_s2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_s1 <= 1'b0;
            int_s2 <= 1'b0;
            int_s3 <= 1'b0;
            db_s1  <= '0;
            db_s2  <= '0;
        end else begin
            int_s1 <= INT;
            int_s2 <= int_s1;
            int_s3 <= int_s2;
            db_s1  <= DB;
            db_s2  <= db_s1;
        end
    end

    assign rise = int_s2 & ~int_s3;
    assign fall = ~int_s2 & int_s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            wr_q    <= 1'b1;
            ovr_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            wr_q    <= wr_d;
            ovr_q   <= ovr_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        wr_d    = 1'b1;
        ovr_d   = 1'b0;
        to_d    = 1'b0;

        if (valid_q && ready)
            valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = WR_LO;
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            WR_LO: begin
                // WR already low for one cycle on entry
                if (cnt_q == WR_LAST) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end else begin
                    wr_d  = 1'b0;
                    cnt_d = cnt_q + ONE;
                end
            end
            WAIT_HI: begin
                if (rise) begin
                    state_d = WAIT_LO;
                end else if (cnt_q == TO_MAX) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            WAIT_LO: begin
                // cnt keeps running: the budget covers the whole wait
                if (fall) begin
                    state_d = CAPTURE;
                end else if (cnt_q == TO_MAX) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            CAPTURE: begin
                state_d = IDLE;
                // a consume in this same cycle frees the register
                if (!valid_q || ready) begin
                    data_d  = db_s2;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign WR          = wr_q;
    assign data        = data_q;
    assign valid       = valid_q;
    assign busy        = (state_q != IDLE);
    assign overrun     = ovr_q;
    assign timeout_err = to_q;

endmodule
